// File: rtl/rv32_types.sv
// Shared RV32 types: register ids, data words, write requests and register-file state.
package rv32_types;

   localparam int unsigned RV_XLEN     = 32;
   localparam int unsigned RV_REG_ID_W = 5;
   localparam int unsigned RV_NUM_REGS = 32;

   typedef logic [RV_REG_ID_W-1:0] rv_reg_id_t;
   typedef logic [RV_XLEN-1:0]     rv32_word;

   typedef struct packed {
      logic       write;
      rv_reg_id_t id;
      rv32_word   data;
   } register_write_request_t;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_t;

endpackage

// File: rtl/rv32_rf_scoreboard.sv
// Busy-bit scoreboard: a reservation marks a register as awaiting writeback,
// a write clears the mark, and a same-cycle reservation beats the write.
module rv32_rf_scoreboard
   import rv32_types::*;
#(
   parameter int unsigned NUM_WRITE_PORTS = 2
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_reserve_valid,
   input  rv_reg_id_t                 i_reserve_id,
   input  logic [NUM_WRITE_PORTS-1:0] i_wr_valid,
   input  rv_reg_id_t                 i_wr_id [NUM_WRITE_PORTS],
   output logic [RV_NUM_REGS-1:0]     o_busy
);

   logic [RV_NUM_REGS-1:0] r_busy;
   logic [RV_NUM_REGS-1:0] w_busy_next;

   // Next busy vector: clear on writeback first, then apply the reservation on top.
   always_comb begin
      w_busy_next = r_busy;
      for (int p = 0; p < int'(NUM_WRITE_PORTS); p++) begin
         if (i_wr_valid[p]) begin
            w_busy_next[i_wr_id[p]] = 1'b0;
         end
      end
      if (i_reserve_valid) begin
         w_busy_next[i_reserve_id] = 1'b1;
      end
      w_busy_next[0] = 1'b0;
   end

   // Busy register with synchronous clear.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/rv32_register_file_mp.sv
// Multi-ported RV32 register file with a post-reset clearing sweep,
// optional write-to-read bypass and a per-register busy scoreboard.
module rv32_register_file_mp
   import rv32_types::*;
#(
   parameter int unsigned NUM_READ_PORTS  = 4,
   parameter int unsigned NUM_WRITE_PORTS = 2,
   parameter int unsigned BYPASS          = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  rv_reg_id_t                rs            [NUM_READ_PORTS],
   output rv32_word                  o             [NUM_READ_PORTS],
   output logic [NUM_READ_PORTS-1:0] o_busy,
   input  register_write_request_t   write_request [NUM_WRITE_PORTS],
   input  logic                      reserve_valid,
   input  rv_reg_id_t                reserve_id,
   output logic                      ready
);

   rf_state_t  r_state;
   rv_reg_id_t r_sweep_idx;
   rv32_word   r_regs [1:RV_NUM_REGS-1];

   logic                       w_ready;
   logic [NUM_WRITE_PORTS-1:0] w_wr_valid;
   rv_reg_id_t                 w_wr_id [NUM_WRITE_PORTS];
   logic [RV_NUM_REGS-1:0]     w_busy;

   assign w_ready = (r_state == RF_READY);
   assign ready   = w_ready;

   // Qualified writes: ignored while clearing, and x0 is never a target.
   always_comb begin
      for (int p = 0; p < int'(NUM_WRITE_PORTS); p++) begin
         w_wr_id[p]    = write_request[p].id;
         w_wr_valid[p] = w_ready && write_request[p].write &&
                         (write_request[p].id != '0);
      end
   end

   rv32_rf_scoreboard #(
      .NUM_WRITE_PORTS (NUM_WRITE_PORTS)
   ) u_scoreboard (
      .clk             (clk),
      .i_rst           (rst),
      .i_reserve_valid (w_ready && reserve_valid),
      .i_reserve_id    (reserve_id),
      .i_wr_valid      (w_wr_valid),
      .i_wr_id         (w_wr_id),
      .o_busy          (w_busy)
   );

   // CLEAR/READY FSM with sweep counter and register array update (highest port wins).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RF_CLEAR;
         r_sweep_idx <= RV_REG_ID_W'(1);
      end else begin
         case (r_state)
            RF_CLEAR: begin
               for (int r = 1; r < int'(RV_NUM_REGS); r++) begin
                  if (r_sweep_idx == RV_REG_ID_W'(r)) begin
                     r_regs[r] <= '0;
                  end
               end
               if (r_sweep_idx == RV_REG_ID_W'(RV_NUM_REGS - 1)) begin
                  r_state <= RF_READY;
               end else begin
                  r_sweep_idx <= r_sweep_idx + RV_REG_ID_W'(1);
               end
            end
            RF_READY: begin
               for (int r = 1; r < int'(RV_NUM_REGS); r++) begin
                  for (int p = 0; p < int'(NUM_WRITE_PORTS); p++) begin
                     if (w_wr_valid[p] && (w_wr_id[p] == RV_REG_ID_W'(r))) begin
                        r_regs[r] <= write_request[p].data;
                     end
                  end
               end
            end
            default: begin
               r_state <= RF_CLEAR;
            end
         endcase
      end
   end

   // Combinational read ports: stored value, optional same-cycle bypass, zero while clearing.
   always_comb begin
      for (int i = 0; i < int'(NUM_READ_PORTS); i++) begin
         o[i] = '0;
         for (int r = 1; r < int'(RV_NUM_REGS); r++) begin
            if (rs[i] == RV_REG_ID_W'(r)) begin
               o[i] = r_regs[r];
            end
         end
         if (BYPASS != 0) begin
            for (int p = 0; p < int'(NUM_WRITE_PORTS); p++) begin
               if (w_wr_valid[p] && (w_wr_id[p] == rs[i])) begin
                  o[i] = write_request[p].data;
               end
            end
         end
         if (!w_ready) begin
            o[i] = '0;
         end
         o_busy[i] = w_ready && w_busy[rs[i]];
      end
   end

endmodule

// File: tb/tb_rv32_register_file_mp.sv
// Directed bench for rv32_register_file_mp: one bypassing and one non-bypassing instance.
module tb_rv32_register_file_mp;
   import rv32_types::*;

   logic                    clk = 1'b0;
   logic                    rst;
   rv_reg_id_t              rs [4];
   rv32_word                o [4];
   rv32_word                o_nb [4];
   logic [3:0]              o_busy;
   logic [3:0]              o_busy_nb;
   register_write_request_t wr [2];
   logic                    reserve_valid;
   rv_reg_id_t              reserve_id;
   logic                    ready;
   logic                    ready_nb;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rv32_register_file_mp #(
      .NUM_READ_PORTS (4), .NUM_WRITE_PORTS (2), .BYPASS (1)
   ) dut (
      .clk (clk), .rst (rst), .rs (rs), .o (o), .o_busy (o_busy),
      .write_request (wr), .reserve_valid (reserve_valid),
      .reserve_id (reserve_id), .ready (ready)
   );

   rv32_register_file_mp #(
      .NUM_READ_PORTS (4), .NUM_WRITE_PORTS (2), .BYPASS (0)
   ) dut_nb (
      .clk (clk), .rst (rst), .rs (rs), .o (o_nb), .o_busy (o_busy_nb),
      .write_request (wr), .reserve_valid (reserve_valid),
      .reserve_id (reserve_id), .ready (ready_nb)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      wr[0]         = '0;
      wr[1]         = '0;
      reserve_valid = 1'b0;
      reserve_id    = '0;
   endtask

   // Counts edges until ready (starting from n_start), bounded; expects 31.
   task automatic wait_ready(input string tag, input int n_start);
      int n;
      n = n_start;
      while (!ready && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(n), 32'd31);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      clr_req();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) rs[k] = '0;
      step();
      step();
      rst = 1'b0;
      rs[0] = 5'd9;
      #1;
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_o", o[0], 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);

      // Write/reserve during the clearing sweep must be ignored.
      for (int k = 0; k < 4; k++) step();
      wr[0] = '{write: 1'b1, id: 5'd9, data: 32'h0000_1234};
      reserve_valid = 1'b1;
      reserve_id    = 5'd9;
      #1;
      check("clear_o_bypass", o[0], 32'd0);
      check("clear_busy", 32'(o_busy[0]), 32'd0);
      step();
      clr_req();
      wait_ready("sweep_len", 5);
      check("ready_nb", 32'(ready_nb), 32'd1);
      check("clear_write_ignored", o[0], 32'd0);
      check("clear_reserve_ignored", 32'(o_busy[0]), 32'd0);

      // Every register reads zero after the sweep.
      for (int g = 0; g < 8; g++) begin
         for (int k = 0; k < 4; k++) rs[k] = 5'(4 * g + k);
         #1;
         for (int k = 0; k < 4; k++) check("zero_after_sweep", o[k], 32'd0);
      end

      // Two ports write x5 in one cycle: port 1 wins.
      rs[0] = 5'd5;
      wr[0] = '{write: 1'b1, id: 5'd5, data: 32'h11};
      wr[1] = '{write: 1'b1, id: 5'd5, data: 32'h22};
      #1;
      check("dual_bypass", o[0], 32'h22);
      check("dual_nobypass_old", o_nb[0], 32'h0);
      step();
      clr_req();
      check("dual_stored", o[0], 32'h22);
      check("dual_stored_nb", o_nb[0], 32'h22);

      // x0 write and reservation are discarded.
      rs[1] = 5'd0;
      wr[0] = '{write: 1'b1, id: 5'd0, data: 32'hDEAD_BEEF};
      reserve_valid = 1'b1;
      reserve_id    = 5'd0;
      #1;
      check("x0_bypass", o[1], 32'd0);
      step();
      clr_req();
      check("x0_read", o[1], 32'd0);
      check("x0_busy", 32'(o_busy[1]), 32'd0);

      // Reservation / writeback of x7.
      rs[2] = 5'd7;
      reserve_valid = 1'b1;
      reserve_id    = 5'd7;
      #1;
      check("rsv_not_yet", 32'(o_busy[2]), 32'd0);
      step();
      clr_req();
      check("rsv_busy", 32'(o_busy[2]), 32'd1);
      wr[0] = '{write: 1'b1, id: 5'd7, data: 32'h5};
      #1;
      check("wb_busy_same_cycle", 32'(o_busy[2]), 32'd1);
      check("wb_bypass", o[2], 32'h5);
      step();
      clr_req();
      check("wb_busy_clear", 32'(o_busy[2]), 32'd0);
      check("wb_value", o[2], 32'h5);
      wr[1] = '{write: 1'b1, id: 5'd7, data: 32'h6};
      reserve_valid = 1'b1;
      reserve_id    = 5'd7;
      step();
      clr_req();
      check("rsv_wins_busy", 32'(o_busy[2]), 32'd1);
      check("rsv_wins_data", o[2], 32'h6);
      check("rsv_wins_busy_nb", 32'(o_busy_nb[2]), 32'd1);

      // Independent writes on both ports, read on all four ports.
      wr[0] = '{write: 1'b1, id: 5'd10, data: 32'hA0A0_0001};
      wr[1] = '{write: 1'b1, id: 5'd11, data: 32'hB0B0_0002};
      step();
      wr[0] = '{write: 1'b1, id: 5'd12, data: 32'hC0C0_0003};
      wr[1] = '0;
      step();
      clr_req();
      rs[0] = 5'd10; rs[1] = 5'd11; rs[2] = 5'd12; rs[3] = 5'd13;
      #1;
      check("multi_r0", o[0], 32'hA0A0_0001);
      check("multi_r1", o[1], 32'hB0B0_0002);
      check("multi_r2", o[2], 32'hC0C0_0003);
      check("multi_r3", o[3], 32'h0);

      // Write x3, then reset mid-sweep at index 10.
      wr[0] = '{write: 1'b1, id: 5'd3, data: 32'h99};
      step();
      clr_req();
      rs[0] = 5'd3;
      rs[1] = 5'd7;
      #1;
      check("x3_written", o[0], 32'h99);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 9; k++) step();
      check("midsweep_ready", 32'(ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("rst_o_zero", o[0], 32'd0);
      wait_ready("resweep_len", 0);
      check("x3_cleared", o[0], 32'd0);
      check("busy_cleared", 32'(o_busy[1]), 32'd0);
      check("x7_cleared", o[1], 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32_register_file_mp.md
RV32_REGISTER_FILE_MP -- requirements
Module: rv32_register_file_mp

Interface
REQ-001 The block SHALL have parameter NUM_READ_PORTS, default 4, number of combinational read ports.
REQ-002 The block SHALL have parameter NUM_WRITE_PORTS, default 2, number of write ports.
REQ-003 The block SHALL have parameter BYPASS, default 1, which enables same-cycle write-to-read forwarding when set to 1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 rs  in  NUM_READ_PORTS x rv_reg_id_t  read register ids.
REQ-008 o  out  NUM_READ_PORTS x rv32_word  read data.
REQ-009 o_busy  out  NUM_READ_PORTS x 1  pending-write flag for each rs.
REQ-010 write_request  in  NUM_WRITE_PORTS x register_write_request_t  write port array; each element carries write, id and data.
REQ-011 reserve_valid  in  1  marks reserve_id as awaiting writeback.
REQ-012 reserve_id  in  rv_reg_id_t  register id to reserve.
REQ-013 ready  out  1  file is initialised and accepting requests.

Function
REQ-014 The block SHALL hold 32 registers of rv32_word, with an FSM of states CLEAR and READY.
REQ-015 In CLEAR, the block SHALL write zero to one register per cycle, indices 1..31 in order, then enter READY on the cycle after index 31 is written (31 cycles total).
REQ-016 In CLEAR: ready=0; write_request and reserve_valid ignored; all o SHALL read 0; all o_busy SHALL read 0.
REQ-017 In READY: ready=1; each asserted write_request SHALL update its register at the next rising edge.
REQ-018 When several write ports target the same id in one cycle, the highest port index SHALL win.
REQ-019 Writes to x0 SHALL be discarded; reads of x0 SHALL return 0 and o_busy=0 at all times.
REQ-020 Read output o SHALL be combinational from rs and stored state, with no latency.
REQ-021 With BYPASS=1, o SHALL return the winning same-cycle write data when rs matches an asserted write id, excluding x0.
REQ-022 With BYPASS=0, o SHALL return the stored value, which is the old value during the write cycle.
REQ-023 reserve_valid SHALL set the busy bit of reserve_id at the next edge; reserving x0 has no effect.
REQ-024 Any asserted write SHALL clear the busy bit of its id at the next edge.
REQ-025 When a reserve and a write target the same id in the same cycle, the busy bit SHALL end set (the new reservation wins).
REQ-026 o_busy SHALL reflect the registered busy bits, with no bypass.

Reset
REQ-027 When rst=1 at a rising edge, the FSM SHALL enter CLEAR with the sweep index at 1, and all busy bits SHALL clear.
REQ-028 Reset asserted mid-sweep or in READY SHALL restart the full 31-cycle sweep.
REQ-029 Output values during and after reset: ready=0; o=0; o_busy=0.

Structure
REQ-030 The rv32_types package SHALL add constant RV_NUM_REGS=32 and enum rf_state_t {RF_CLEAR, RF_READY}.
REQ-031 The busy-bit logic SHALL be a sub-module, rv32_rf_scoreboard, with inputs reserve, write ids and rst, and a 32-bit busy vector output.
REQ-032 register_write_request_t SHALL be reused unchanged.

Verification
REQ-033 Reset, then idle for 31 cycles -> ready rises on cycle 32; reading every register returns 0.
REQ-034 Ports 0 and 1 both write x5 (0x11, 0x22) in one cycle -> x5=0x22 next cycle; with BYPASS=1, o shows 0x22 in the same cycle.
REQ-035 Write x0=0xDEADBEEF with reserve_id=0 -> o=0 and o_busy=0.
REQ-036 Reserve x7 -> o_busy=1 the next cycle; write x7=0x5 -> busy=0 the next cycle; a reserve and write of x7 in the same cycle -> busy stays 1.
REQ-037 Assert rst at sweep index 10, with x3=0x99 written before the sweep -> the sweep restarts, ready rises 31 cycles after rst drops, and x3 reads 0.
REQ-038 Apply write_request during CLEAR -> the write is ignored; the register reads 0 after ready.
